bsg_manycore_host_mmio_responder: RTL

Host-side responder on the manycore I/O link. It is the target end for remote requests that tiles send to the I/O coordinate, as opposed to the host-initiated requests the DPI endpoint drives into the array. It decodes load/store requests against a small host MMIO map (finish, fail, print-stat, cycle counter, scratch) and returns one response packet per request. It raises single-cycle event pulses that the testbench consumes.

---
 rtl/bsg_manycore_host_mmio_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_host_mmio_responder.sv
// Host MMIO responder: decodes tile load/store requests against
// finish/fail/print-stat, a 64-bit cycle counter and scratch words.
// Ports: clk_i/reset_n_i; req_* valid/ready request in;
// rsp_* valid/yumi response out; *_v_o event pulses + event_data_o;
// error_o sticky illegal-op / unmapped-address flag.
module bsg_manycore_host_mmio_responder #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int reg_id_width_p = 5,
  parameter int num_scratch_p  = 8,
  parameter int rsp_fifo_els_p = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      req_v_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [addr_width_p-1:0]   req_addr_i,
  input  logic [data_width_p-1:0]   req_data_i,
  input  logic [3:0]                req_mask_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  input  logic [reg_id_width_p-1:0] req_reg_id_i,
  output logic                      rsp_v_o,
  input  logic                      rsp_yumi_i,
  output logic                      rsp_is_load_o,
  output logic [data_width_p-1:0]   rsp_data_o,
  output logic [reg_id_width_p-1:0] rsp_reg_id_o,
  output logic [x_cord_width_p-1:0] rsp_dst_x_o,
  output logic [y_cord_width_p-1:0] rsp_dst_y_o,
  output logic                      finish_v_o,
  output logic                      fail_v_o,
  output logic                      print_stat_v_o,
  output logic [data_width_p-1:0]   event_data_o,
  output logic                      error_o
);

  localparam int AW = addr_width_p;
  localparam int DW = data_width_p;
  localparam int NE = rsp_fifo_els_p;
  localparam int PW = $clog2(NE);
  localparam int CW = $clog2(NE + 1);
  localparam int SW = (num_scratch_p > 1) ? $clog2(num_scratch_p) : 1;

  typedef struct packed {
    logic                      is_load;
    logic [DW-1:0]             data;
    logic [reg_id_width_p-1:0] reg_id;
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;
  } rsp_t;

  rsp_t          mem_q [NE];
  rsp_t          rsp_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   ctr_q;
  logic [DW-1:0] shadow_q;
  logic [DW-1:0] scratch_q [num_scratch_p];
  logic          fin_q, fail_q, stat_q, err_q;
  logic [DW-1:0] evt_q;

  logic          enq, deq;
  logic          is_ld, is_st, is_bad;
  logic          hit_fin, hit_fail, hit_stat;
  logic          hit_lo, hit_hi, hit_scr, unmapped;
  logic [AW-1:0] off;
  logic [SW-1:0] sidx;
  logic          fin_d, fail_d, stat_d, err_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready_o = reset_n_i & (cnt_q < CW'(NE));
  assign rsp_v_o     = (cnt_q != '0);
  assign enq         = req_v_i & req_ready_o;
  assign deq         = rsp_yumi_i & rsp_v_o;

  assign is_ld  = (req_op_i == 2'd0);
  assign is_st  = (req_op_i == 2'd1);
  assign is_bad = req_op_i[1];

  assign off      = req_addr_i - AW'(8);
  assign sidx     = off[SW-1:0];
  assign hit_fin  = (req_addr_i == AW'(0));
  assign hit_fail = (req_addr_i == AW'(1));
  assign hit_stat = (req_addr_i == AW'(2));
  assign hit_lo   = (req_addr_i == AW'(3));
  assign hit_hi   = (req_addr_i == AW'(4));
  assign hit_scr  = (req_addr_i >= AW'(8)) &&
                    (off < AW'(num_scratch_p));
  assign unmapped = ~(hit_fin | hit_fail | hit_stat |
                      hit_lo | hit_hi | hit_scr);

  always_comb begin
    rsp_d         = '0;
    rsp_d.is_load = is_ld;
    rsp_d.reg_id  = req_reg_id_i;
    rsp_d.x       = req_src_x_i;
    rsp_d.y       = req_src_y_i;
    unique case (1'b1)
      is_ld & hit_lo:   rsp_d.data = ctr_q[31:0];
      is_ld & hit_hi:   rsp_d.data = shadow_q;
      is_ld & hit_scr:  rsp_d.data = scratch_q[sidx];
      is_ld & unmapped: rsp_d.data = 32'hDEAD_BEEF;
      default:          rsp_d.data = '0;
    endcase
  end

  assign fin_d  = enq & is_st & hit_fin;
  assign fail_d = enq & is_st & hit_fail;
  assign stat_d = enq & is_st & hit_stat;
  assign err_d  = err_q | (enq & (is_bad | unmapped));

  always_comb begin
    wptr_d = enq ? nxt(wptr_q) : wptr_q;
    rptr_d = deq ? nxt(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(enq) - CW'(deq);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      ctr_q    <= '0;
      shadow_q <= '0;
      fin_q    <= 1'b0;
      fail_q   <= 1'b0;
      stat_q   <= 1'b0;
      err_q    <= 1'b0;
      evt_q    <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ctr_q  <= ctr_q + 64'd1;
      fin_q  <= fin_d;
      fail_q <= fail_d;
      stat_q <= stat_d;
      err_q  <= err_d;
      if (fin_d | fail_d | stat_d)
        evt_q <= req_data_i;
      if (enq & is_ld & hit_lo)
        shadow_q <= ctr_q[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_scratch_p; i++)
        scratch_q[i] <= '0;
    end else if (enq & is_st & hit_scr) begin
      for (int b = 0; b < 4; b++)
        if (req_mask_i[b])
          scratch_q[sidx][8*b +: 8] <= req_data_i[8*b +: 8];
    end
  end

  // Payload storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (enq)
      mem_q[wptr_q] <= rsp_d;
  end

  assign rsp_is_load_o  = mem_q[rptr_q].is_load;
  assign rsp_data_o     = mem_q[rptr_q].data;
  assign rsp_reg_id_o   = mem_q[rptr_q].reg_id;
  assign rsp_dst_x_o    = mem_q[rptr_q].x;
  assign rsp_dst_y_o    = mem_q[rptr_q].y;
  assign finish_v_o     = fin_q;
  assign fail_v_o       = fail_q;
  assign print_stat_v_o = stat_q;
  assign event_data_o   = evt_q;
  assign error_o        = err_q;

endmodule
